// File: rtl/ward_pkg.sv
// Shared encodings and default timing constants for the ward alarm arbiter.
package ward_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_OFFER     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_ESCALATED = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_CLOCKS_PER_SECOND = 1000000;
    localparam int unsigned DEFAULT_ACK_TIMEOUT       = 60;
    localparam int unsigned SEC_CNT_W                 = 16;

endpackage

// File: rtl/sec_tick_gen.sv
// One-cycle tick every CLOCKS_PER_SECOND enabled cycles; clear forces the
// prescaler back to zero so each acknowledge window starts on a fresh second.
module sec_tick_gen
    import ward_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_SECOND = DEFAULT_CLOCKS_PER_SECOND
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned W = (CLOCKS_PER_SECOND > 1) ? $clog2(CLOCKS_PER_SECOND) : 1;
    localparam logic [W-1:0] LAST = W'(CLOCKS_PER_SECOND - 1);

    logic [W-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ward_alarm_arbiter.sv
// Latches bed fall alarms and offers them one at a time, round-robin, to a
// shared nurse-call channel; escalates when an accepted call goes unacknowledged.
module ward_alarm_arbiter
    import ward_pkg::*;
#(
    parameter int unsigned NUM_BEDS          = 4,
    parameter int unsigned CLOCKS_PER_SECOND = DEFAULT_CLOCKS_PER_SECOND,
    parameter int unsigned ACK_TIMEOUT       = DEFAULT_ACK_TIMEOUT,
    localparam int unsigned BED_W            = (NUM_BEDS > 1) ? $clog2(NUM_BEDS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BEDS-1:0] bed_alarm,
    output logic                call_valid,
    input  logic                call_ready,
    output logic [BED_W-1:0]    call_bed,
    input  logic                nurse_ack,
    output logic                escalate,
    output logic [NUM_BEDS-1:0] pending
);

    localparam logic [SEC_CNT_W-1:0] TIMEOUT_LAST = SEC_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [BED_W-1:0]     LAST_BED     = BED_W'(NUM_BEDS - 1);

    state_t                state;
    logic [BED_W-1:0]      rr_ptr;
    logic [BED_W-1:0]      winner;
    logic [BED_W-1:0]      next_ptr;
    logic [NUM_BEDS-1:0]   alarm_prev;
    logic [NUM_BEDS-1:0]   rise;
    logic [NUM_BEDS-1:0]   ack_clear;
    logic                  armed;
    logic                  ack_take;
    logic                  tick;
    logic [SEC_CNT_W-1:0]  sec_count;

    // armed masks the first cycle after reset so a level held through reset is not an edge
    assign rise     = armed ? (bed_alarm & ~alarm_prev) : '0;
    assign ack_take = nurse_ack && (state == ST_WAIT_ACK || state == ST_ESCALATED);
    assign next_ptr = (call_bed == LAST_BED) ? '0 : call_bed + 1'b1;

    always_comb begin
        ack_clear = '0;
        if (ack_take) ack_clear[call_bed] = 1'b1;
    end

    // Scan offsets high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        winner = rr_ptr;
        for (int k = int'(NUM_BEDS) - 1; k >= 0; k--) begin
            if (pending[(int'(rr_ptr) + k) % int'(NUM_BEDS)])
                winner = BED_W'((int'(rr_ptr) + k) % int'(NUM_BEDS));
        end
    end

    sec_tick_gen #(
        .CLOCKS_PER_SECOND(CLOCKS_PER_SECOND)
    ) u_sec_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != ST_WAIT_ACK),
        .enable (state == ST_WAIT_ACK),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_prev <= '0;
            armed      <= 1'b0;
            pending    <= '0;
        end else begin
            alarm_prev <= bed_alarm;
            armed      <= 1'b1;
            pending    <= (pending & ~ack_clear) | rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_count <= '0;
        end else if (state != ST_WAIT_ACK) begin
            sec_count <= '0;
        end else if (tick) begin
            sec_count <= sec_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            call_valid <= 1'b0;
            call_bed   <= '0;
            escalate   <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        state      <= ST_OFFER;
                        call_valid <= 1'b1;
                        call_bed   <= winner;
                    end
                end
                ST_OFFER: begin
                    if (call_ready) begin
                        state      <= ST_WAIT_ACK;
                        call_valid <= 1'b0;
                    end
                end
                ST_WAIT_ACK: begin
                    // an acknowledge landing on the timeout tick still wins
                    if (nurse_ack) begin
                        state  <= ST_IDLE;
                        rr_ptr <= next_ptr;
                    end else if (tick && sec_count == TIMEOUT_LAST) begin
                        state    <= ST_ESCALATED;
                        escalate <= 1'b1;
                    end
                end
                ST_ESCALATED: begin
                    if (nurse_ack) begin
                        state    <= ST_IDLE;
                        escalate <= 1'b0;
                        rr_ptr   <= next_ptr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ward_alarm_arbiter.sv
// Bench for ward_alarm_arbiter: table vectors, directed corner sequences and
// random traffic, all compared against a cycle-level behavioural model.
module tb_ward_alarm_arbiter;

    localparam int N   = 4;
    localparam int CPS = 10;
    localparam int TO  = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] bed_alarm = '0;
    logic         call_valid;
    logic         call_ready = 1'b0;
    logic [1:0]   call_bed;
    logic         nurse_ack = 1'b0;
    logic         escalate;
    logic [N-1:0] pending;

    int total = 0;
    int bad = 0;

    ward_alarm_arbiter #(
        .NUM_BEDS(N), .CLOCKS_PER_SECOND(CPS), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .bed_alarm(bed_alarm),
        .call_valid(call_valid), .call_ready(call_ready), .call_bed(call_bed),
        .nurse_ack(nurse_ack), .escalate(escalate), .pending(pending)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 offering, 2 waiting, 3 escalated.
    int           m_mode, m_rr, m_bed, m_elapsed;
    logic         m_valid, m_esc, m_armed;
    logic [N-1:0] m_pend, m_prev;

    task automatic model_reset();
        m_mode = 0; m_rr = 0; m_bed = 0; m_elapsed = 0;
        m_valid = 0; m_esc = 0; m_armed = 0; m_pend = '0; m_prev = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] np;
        int nb;
        np = m_pend;
        nb = -1;
        case (m_mode)
            0: if (m_pend != 0) begin
                for (int o = 0; o < N; o++)
                    if (nb < 0 && m_pend[(m_rr + o) % N]) nb = (m_rr + o) % N;
                m_bed = nb; m_valid = 1; m_mode = 1;
            end
            1: if (call_ready) begin m_valid = 0; m_mode = 2; m_elapsed = 0; end
            2: begin
                m_elapsed++;
                if (nurse_ack) begin
                    np[m_bed] = 1'b0; m_rr = (m_bed + 1) % N; m_mode = 0;
                end else if (m_elapsed == TO * CPS) begin
                    m_esc = 1; m_mode = 3;
                end
            end
            default: if (nurse_ack) begin
                np[m_bed] = 1'b0; m_rr = (m_bed + 1) % N; m_esc = 0; m_mode = 0;
            end
        endcase
        if (m_armed) np = np | (bed_alarm & ~m_prev);
        m_pend = np; m_prev = bed_alarm; m_armed = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model_valid", 32'(call_valid), 32'(m_valid));
        chk("model_bed", 32'(call_bed), 32'(m_bed));
        chk("model_esc", 32'(escalate), 32'(m_esc));
        chk("model_pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_valid", 32'(call_valid), 0);
        chk("rst_bed", 32'(call_bed), 0);
        chk("rst_esc", 32'(escalate), 0);
        chk("rst_pending", 32'(pending), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Wait (bounded) for an offer, check its bed, then complete the handshake.
    task automatic to_handshake(input int exp_bed);
        int n;
        n = 0;
        call_ready = 1'b1;
        while (!call_valid && n < 20) begin cycle(); n++; end
        chk("offer_seen", 32'(call_valid), 1);
        chk("offer_bed", 32'(call_bed), 32'(exp_bed));
        cycle();
    endtask

    task automatic ack_now();
        nurse_ack = 1'b1;
        cycle();
        nurse_ack = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] alarm;
        logic         ready;
        logic         ack;
        logic         valid;
        logic [1:0]   bed;
        logic         esc;
        logic [N-1:0] pend;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0010};
        tbl[2]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0010};
        tbl[3]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0010};
        tbl[4]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000};
        tbl[6]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0010};
        tbl[7]  = '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0010};
        tbl[8]  = '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0010};
        tbl[9]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0010};
        tbl[10] = '{4'b0010, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
        tbl[11] = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // single alarm, ignored early acks, held level not re-latching
        foreach (tbl[i]) begin
            bed_alarm = tbl[i].alarm; call_ready = tbl[i].ready; nurse_ack = tbl[i].ack;
            cycle();
            chk("tbl_valid", 32'(call_valid), 32'(tbl[i].valid));
            chk("tbl_bed", 32'(call_bed), 32'(tbl[i].bed));
            chk("tbl_esc", 32'(escalate), 32'(tbl[i].esc));
            chk("tbl_pending", 32'(pending), 32'(tbl[i].pend));
        end
        nurse_ack = 1'b0; bed_alarm = '0;

        // round-robin: 1001 from rr=0 serves 0 then 3; from rr=2 serves 3 then 0
        do_reset();
        cycle();
        bed_alarm = 4'b1001;
        cycle();
        to_handshake(0); ack_now();
        to_handshake(3); ack_now();
        chk("rr_drained", 32'(pending), 0);
        bed_alarm = 4'b0010; cycle();
        to_handshake(1); ack_now();
        bed_alarm = 4'b0000; cycle();
        bed_alarm = 4'b1001; cycle();
        to_handshake(3); ack_now();
        to_handshake(0); ack_now();
        bed_alarm = 4'b0000;

        // backpressure: offer held steady for 20 cycles
        cycle();
        bed_alarm = 4'b0100; call_ready = 1'b0;
        cycle(); cycle();
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("bp_valid", 32'(call_valid), 1);
            chk("bp_bed", 32'(call_bed), 2);
            chk("bp_esc", 32'(escalate), 0);
        end
        to_handshake(2); ack_now();

        // timeout: escalate exactly 30 cycles after the handshake edge
        bed_alarm = 4'b0000; cycle();
        bed_alarm = 4'b1000; cycle();
        to_handshake(3);
        for (int n = 1; n <= TO * CPS; n++) begin
            cycle();
            chk("to_escalate", 32'(escalate), (n == TO * CPS) ? 1 : 0);
        end
        ack_now();
        chk("to_cleared", 32'(escalate), 0);
        chk("to_pending", 32'(pending), 0);

        // acknowledge on the timeout cycle wins
        bed_alarm = 4'b0000; cycle();
        bed_alarm = 4'b0001; cycle();
        to_handshake(0);
        for (int n = 1; n < TO * CPS; n++) cycle();
        ack_now();
        chk("col_escalate", 32'(escalate), 0);
        chk("col_pending", 32'(pending), 0);
        for (int n = 0; n < 5; n++) cycle();
        chk("col_no_late_esc", 32'(escalate), 0);

        // reset in WAIT_ACK with bed 2 held high across reset
        bed_alarm = 4'b0000; cycle();
        bed_alarm = 4'b0100; cycle();
        to_handshake(2);
        repeat (3) cycle();
        do_reset();
        for (int n = 0; n < 10; n++) cycle();
        chk("rr_hold_valid", 32'(call_valid), 0);
        chk("rr_hold_pending", 32'(pending), 0);
        bed_alarm = 4'b0000; cycle();
        bed_alarm = 4'b0100; cycle();
        to_handshake(2); ack_now();

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 9) == 0) bed_alarm[b] = ~bed_alarm[b];
            call_ready = ($urandom_range(0, 1) == 1);
            nurse_ack  = ($urandom_range(0, 15) == 0);
            cycle();
        end
        nurse_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ward_alarm_arbiter.md
WARD_ALARM_ARBITER -- requirements
Module: ward_alarm_arbiter

Interface
REQ-001 Parameter NUM_BEDS, default 4: number of bed fall detectors sharing one nurse-call channel.
REQ-002 Parameter CLOCKS_PER_SECOND, default 1000000: clk cycles per one-second tick.
REQ-003 Parameter ACK_TIMEOUT, default 60: seconds allowed for a nurse acknowledge before escalation.
REQ-004 clk  in  1  single clock, all logic on posedge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 bed_alarm  in  NUM_BEDS  level alarm from each bed's fall detector.
REQ-007 call_valid  out  1  nurse-call request offered.
REQ-008 call_ready  in  1  nurse-call channel accepts request.
REQ-009 call_bed  out  clog2(NUM_BEDS)  index of bed being offered or serviced.
REQ-010 nurse_ack  in  1  nurse confirms attendance for call_bed.
REQ-011 escalate  out  1  acknowledge timeout, supervisor alert.
REQ-012 pending  out  NUM_BEDS  latched, not-yet-acknowledged alarms.

Function
REQ-013 pending[i] SHALL set on a 0->1 edge of bed_alarm[i] (registered previous value); a level held high SHALL NOT re-set it after clearing.
REQ-014 pending[i] SHALL clear only on nurse_ack for bed i; a same-cycle new edge on bed i SHALL win (bit stays set).
REQ-015 FSM states: IDLE, OFFER, WAIT_ACK, ESCALATED.
REQ-016 IDLE: pending != 0 -> OFFER next cycle; call_bed SHALL latch the round-robin winner at that transition.
REQ-017 Round-robin: search starts at rr_ptr, wraps modulo NUM_BEDS; rr_ptr SHALL become (serviced bed + 1) mod NUM_BEDS on acknowledge.
REQ-018 OFFER: call_valid = 1, call_bed stable; call_valid && call_ready -> WAIT_ACK; call_valid SHALL NOT drop before handshake.
REQ-019 WAIT_ACK: second counter starts at 0 on entry; nurse_ack -> clear pending[call_bed], update rr_ptr, IDLE.
REQ-020 WAIT_ACK: counter reaching ACK_TIMEOUT ticks (ACK_TIMEOUT*CLOCKS_PER_SECOND cycles after handshake cycle) -> ESCALATED, escalate = 1.
REQ-021 ESCALATED: escalate held 1; nurse_ack -> clear pending[call_bed], update rr_ptr, escalate = 0, IDLE.
REQ-022 nurse_ack in the timeout cycle SHALL take priority: acknowledge, no escalation.
REQ-023 nurse_ack in IDLE or OFFER SHALL be ignored.
REQ-024 bed_alarm falling while its call is in progress SHALL NOT abort the call; nurse_ack still required.
REQ-025 Prescaler and second counter SHALL count only in WAIT_ACK; counters SHALL not wrap (ACK_TIMEOUT <= 2^16-1).

Reset
REQ-026 On reset: state IDLE, call_valid 0, call_bed 0, escalate 0, pending 0, rr_ptr 0, counters 0, edge-detect registers 0.
REQ-027 Reset mid-call SHALL discard all pending alarms; a bed_alarm held high through reset SHALL NOT register an edge at release.

Structure
REQ-028 Package ward_pkg SHALL hold FSM state encodings and default CLOCKS_PER_SECOND/ACK_TIMEOUT constants.
REQ-029 Sub-module sec_tick_gen SHALL provide the one-cycle-per-second tick with synchronous clear enable.

Verification (bench: NUM_BEDS=4, CLOCKS_PER_SECOND=10, ACK_TIMEOUT=3)
REQ-030 Single alarm: bed_alarm=0010, call_ready=1 -> call_bed=1, call_valid one cycle; nurse_ack -> pending=0000, IDLE.
REQ-031 Round-robin: bed_alarm 1001 same cycle -> serve bed 0 then bed 3; repeat with 1001 -> bed 3 wins when rr_ptr=1..3, then bed 0.
REQ-032 Backpressure: call_ready=0 for 20 cycles -> call_valid and call_bed stable throughout, no escalation.
REQ-033 Timeout: no nurse_ack -> escalate rises exactly 30 cycles after handshake; nurse_ack -> escalate 0 next cycle.
REQ-034 Ack/timeout collision: nurse_ack on cycle 30 -> escalate stays 0, pending bit cleared.
REQ-035 Reset mid-WAIT_ACK with bed_alarm=0100 held -> all outputs 0, no new call after release until bed 2 re-edges.
